// File: rtl/batch_pcm_out_pkg.sv
// Shared constants, stage payload types and the float-to-PCM rounding/saturation helper
// for the batch filter PCM output stage.
package batch_pcm_out_pkg;

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned MANT_W = 23;
   localparam int unsigned PCM_W  = 16;
   localparam int unsigned F      = PCM_W - 1;
   localparam int unsigned B      = 2 ** (EXP_W - 1) - 1;
   localparam int unsigned SH_W   = 16;
   localparam int unsigned SIG_IW = $clog2(MANT_W + 1);

   typedef struct packed {
      logic                   sgn;
      logic                   zero;
      logic                   big;
      logic                   tiny;
      logic                   exact_one;
      logic signed [SH_W-1:0] sh;
      logic [MANT_W:0]        sig;
   } s1_t;

   typedef struct packed {
      logic signed [31:0] val;
      logic               clip;
   } sat_t;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   // Align the significand to Q1.f, round half away from zero, saturate to [-2^f, 2^f-1].
   function automatic sat_t pcm_round_sat(input logic sgn, input logic zero, input logic big,
                                          input logic tiny, input logic exact_one, input int sh,
                                          input logic [MANT_W:0] sig, input int f);
      sat_t   r;
      longint m;
      longint lim;
      r.val  = '0;
      r.clip = 1'b0;
      lim    = longint'(1) << f;
      m      = 0;
      if (!big && !zero && !tiny) begin
         if (sh >= 0) begin
            m = longint'(sig) << sh;
         end else begin
            m = longint'(sig) >> (-sh);
            m = m + longint'(sig[SIG_IW'(-sh - 1)]);
         end
      end
      if (zero || tiny) begin
         r.val = '0;
      end else if (!sgn && (big || m >= lim)) begin
         r.val  = 32'(lim - 1);
         r.clip = 1'b1;
      end else if (sgn && big) begin
         r.val  = 32'(-lim);
         r.clip = !exact_one;
      end else if (sgn && m > lim) begin
         r.val  = 32'(-lim);
         r.clip = 1'b1;
      end else begin
         r.val = sgn ? 32'(-m) : 32'(m);
      end
      return r;
   endfunction

endpackage

// File: rtl/batch_pcm_out_if.sv
// Stream and status bundle between the PCM output stage (slave) and its host (master).
interface batch_pcm_out_if import batch_pcm_out_pkg::*; #(
   parameter int unsigned IN_W  = EXP_W + MANT_W + 1,
   parameter int unsigned OUT_W = PCM_W,
   parameter int unsigned DEPTH = 8
) ();
   localparam int unsigned LVL_W = ptr_w(DEPTH);

   logic             in_valid;
   logic [IN_W-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic [LVL_W-1:0] fifo_level;
   logic             warm;
   logic             clip;
   logic             overflow;
   logic             clr_ovf;

   modport master (
      output in_valid, in_data, out_ready, clr_ovf,
      input  out_valid, out_data, fifo_level, warm, clip, overflow
   );

   modport slave (
      input  in_valid, in_data, out_ready, clr_ovf,
      output out_valid, out_data, fifo_level, warm, clip, overflow
   );
endinterface

// File: rtl/batch_pcm_out_pcm_fifo.sv
// First-word-fall-through FIFO with level, full/empty and a sticky overflow on write-when-full.
module pcm_fifo import batch_pcm_out_pkg::*; #(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr,
   input  logic [W-1:0]             wdata,
   input  logic                     rd,
   output logic [W-1:0]             rdata,
   output logic                     empty,
   output logic                     full,
   output logic [ptr_w(DEPTH)-1:0]  level,
   input  logic                     clr_ovf,
   output logic                     ovf
);
   localparam int unsigned PW = ptr_w(DEPTH);
   localparam int unsigned AW = PW - 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic [W-1:0]  hold;
   logic          wr_ok;
   logic          rd_ok;

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign rd_ok = rd && !empty;
   // A same-cycle read frees the slot, so a write into a full FIFO still lands.
   assign wr_ok = wr && (!full || rd_ok);
   assign level = wp - rp;
   assign rdata = empty ? hold : mem[rp[AW-1:0]];

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wp[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wp   <= '0;
         rp   <= '0;
         hold <= '0;
         ovf  <= 1'b0;
      end else begin
         if (wr_ok) wp <= wp + 1'b1;
         if (rd_ok) begin
            rp   <= rp + 1'b1;
            hold <= mem[rp[AW-1:0]];
         end
         if (wr && !wr_ok)  ovf <= 1'b1;
         else if (clr_ovf)  ovf <= 1'b0;
      end
   end
endmodule

// File: rtl/batch_pcm_out.sv
// Float result -> saturated Q1.(OUT_W-1) PCM with warm-up discard and FWFT output FIFO.
// Optional TPDF dither enabled by defining PCM_DITHER_EN.
module batch_pcm_out import batch_pcm_out_pkg::*; #(
   parameter int unsigned OUT_W      = F + 1,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned DISCARD    = 96
) (
   input  logic            clk,
   input  logic            rst,
   batch_pcm_out_if.slave  bus
);
   localparam int unsigned F_L   = OUT_W - 1;
   localparam int unsigned CNT_W = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;

   logic [CNT_W-1:0] cnt;
   logic             warm_q;
   logic             v1;
   logic             v2;
   s1_t              s1;
   s1_t              s1_c;
   int               e_c;
   sat_t             sat;
   logic [OUT_W-1:0] s2_val;
   logic [OUT_W-1:0] s2_val_c;
   logic             s2_clip;
   logic             s2_clip_c;
   logic             clip_q;
   logic             full;
   logic             empty;
   logic             accept;

   assign accept = bus.in_valid && warm_q;

   // Stage 1 decode: classify the exponent and derive the alignment shift.
   always_comb begin
      e_c            = int'(bus.in_data[MANT_W +: EXP_W]) - int'(B);
      s1_c.sgn       = bus.in_data[EXP_W + MANT_W];
      s1_c.zero      = (bus.in_data[MANT_W +: EXP_W] == '0);
      s1_c.big       = (e_c >= 0);
      s1_c.tiny      = (e_c + int'(F_L) < -1);
      s1_c.exact_one = (e_c == 0) && (bus.in_data[MANT_W-1:0] == '0);
      s1_c.sh        = SH_W'(int'(F_L) + e_c - int'(MANT_W));
      s1_c.sig       = {1'b1, bus.in_data[MANT_W-1:0]};
   end

`ifdef PCM_DITHER_EN
   localparam int LIM = 2 ** F_L;
   logic [15:0] lfsr;
   int          dith_v;

   always_ff @(posedge clk) begin
      if (!rst)        lfsr <= 16'hACE1;
      else if (accept) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end
`endif

   // Stage 2: round/saturate, plus optional +-1 LSB dither that saturates the same way.
   always_comb begin
      sat       = pcm_round_sat(s1.sgn, s1.zero, s1.big, s1.tiny, s1.exact_one,
                                int'($signed(s1.sh)), s1.sig, int'(F_L));
      s2_val_c  = OUT_W'(sat.val);
      s2_clip_c = sat.clip;
`ifdef PCM_DITHER_EN
      dith_v = int'($signed(sat.val)) + int'(lfsr[0]) - int'(lfsr[1]);
      if (!sat.clip) begin
         if (dith_v > LIM - 1) begin
            s2_val_c  = OUT_W'(LIM - 1);
            s2_clip_c = 1'b1;
         end else if (dith_v < -LIM) begin
            s2_val_c  = OUT_W'(-LIM);
            s2_clip_c = 1'b1;
         end else begin
            s2_val_c  = OUT_W'(dith_v);
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt     <= '0;
         warm_q  <= (DISCARD == 0);
         v1      <= 1'b0;
         v2      <= 1'b0;
         s1      <= '0;
         s2_val  <= '0;
         s2_clip <= 1'b0;
         clip_q  <= 1'b0;
      end else begin
         v1 <= accept;
         if (accept) s1 <= s1_c;
         if (bus.in_valid && !warm_q) begin
            cnt <= cnt + 1'b1;
            if (CNT_W'(cnt + 1'b1) == CNT_W'(DISCARD)) warm_q <= 1'b1;
         end
         v2 <= v1;
         if (v1) begin
            s2_val  <= s2_val_c;
            s2_clip <= s2_clip_c;
         end
         // Only samples that actually land in the FIFO report a clip.
         clip_q <= v2 && s2_clip && (!full || bus.out_ready);
      end
   end

   pcm_fifo #(.W(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr      (v2),
      .wdata   (s2_val),
      .rd      (bus.out_ready),
      .rdata   (bus.out_data),
      .empty   (empty),
      .full    (full),
      .level   (bus.fifo_level),
      .clr_ovf (bus.clr_ovf),
      .ovf     (bus.overflow)
   );

   assign bus.out_valid = !empty;
   assign bus.warm      = warm_q;
   assign bus.clip      = clip_q;
endmodule

// File: tb/tb_batch_pcm_out.sv
// Directed + randomized bench for batch_pcm_out against a real-arithmetic PCM model.
module tb_batch_pcm_out;
   logic clk = 1'b0;
   logic rst;

   batch_pcm_out_if #(.IN_W(32), .OUT_W(16), .DEPTH(4)) bus ();

   batch_pcm_out #(.OUT_W(16), .FIFO_DEPTH(4), .DISCARD(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          n_cmp     = 0;
   int          n_bad     = 0;
   int          clip_exp  = 0;
   int          clip_got  = 0;
   int          disc_left = 3;
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];

   // Record every accepted word and clip pulse, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
         if (bus.clip) clip_got++;
      end
   end

   // Value = +-1.mant * 2^(exp-127); scale by 2^15, round half away, clamp to [-1, 1).
   function automatic void model(input logic [31:0] w, output logic [15:0] pcm, output logic c);
      int  ex;
      real mag;
      int  m;
      ex  = int'(w[30:23]);
      c   = 1'b0;
      pcm = 16'h0000;
      if (ex != 0) begin
         mag = 1.0 + real'(w[22:0]) / 8388608.0;
         for (int i = 0; i < ex - 127; i++) mag = mag * 2.0;
         for (int i = 0; i < 127 - ex; i++) mag = mag / 2.0;
         if (!w[31]) begin
            if (mag >= 1.0) m = 32768;
            else            m = $rtoi(mag * 32768.0 + 0.5);
            if (m >= 32768) begin pcm = 16'h7FFF; c = 1'b1; end
            else            pcm = 16'(m);
         end else begin
            if (mag > 1.0) begin pcm = 16'h8000; c = 1'b1; end
            else begin
               m   = $rtoi(mag * 32768.0 + 0.5);
               pcm = 16'(-m);
            end
         end
      end
   endfunction

   function automatic logic [31:0] rnd_float();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 15) == 0) r[30:23] = 8'h00;
      else                            r[30:23] = 8'($urandom_range(97, 137));
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w);
      logic [15:0] p;
      logic        c;
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      if (disc_left > 0) disc_left--;
      else begin
         model(w, p, c);
         exp_q.push_back(p);
         if (c) clip_exp++;
      end
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      bus.out_ready = 1'b1;
      repeat (12) step();
      chk({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      chk({tag, " clips"}, 32'(clip_got), 32'(clip_exp));
      chk({tag, " level"}, 32'(bus.fifo_level), 32'd0);
      got_q.delete();
      exp_q.delete();
      clip_got = 0;
      clip_exp = 0;
   endtask

   initial begin
      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      bus.clr_ovf   = 1'b0;
      repeat (2) step();
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst out_data",  32'(bus.out_data),  32'd0);
      chk("rst level",     32'(bus.fifo_level), 32'd0);
      chk("rst warm",      32'(bus.warm),      32'd0);
      chk("rst clip",      32'(bus.clip),      32'd0);
      chk("rst overflow",  32'(bus.overflow),  32'd0);
      rst = 1'b1;

      // Warm-up discard then one 0.5 sample.
      bus.out_ready = 1'b1;
      send(32'h3F000000);
      send(32'h3F000000);
      chk("t1 warm after 2", 32'(bus.warm), 32'd0);
      send(32'h3F000000);
      chk("t1 warm after 3", 32'(bus.warm), 32'd1);
      send(32'h3F000000);
      drain("t1");

      send(32'hBE800000);
      send(32'hBF800000);
      send(32'h00000000);
      drain("t2");

      send(32'h3FC00000);
      send(32'h3F7FFFFF);
      send(32'hC0000000);
      drain("t3");

      // Random traffic, throttled so the FIFO can never overflow.
      for (int i = 0; i < 300; i++) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if (bus.fifo_level <= 3'd1 && $urandom_range(0, 1) == 1) send(rnd_float());
         else step();
      end
      chk("rand overflow", 32'(bus.overflow), 32'd0);
      drain("rand");

      // Overflow with the sink stalled.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(32'h3E800000 + (32'(i) << 20));
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      repeat (3) step();
      chk("t4 level",     32'(bus.fifo_level), 32'd4);
      chk("t4 overflow",  32'(bus.overflow),   32'd1);
      chk("t4 out_valid", 32'(bus.out_valid),  32'd1);
      chk("t4 head",      32'(bus.out_data),   32'(exp_q[0]));
      bus.clr_ovf = 1'b1;
      step();
      bus.clr_ovf = 1'b0;
      chk("t4 clr_ovf",   32'(bus.overflow),   32'd0);
      chk("t4 level kept", 32'(bus.fifo_level), 32'd4);

      // Write and read meet while full.
      send(32'hBE000000);
      step();
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk("t5 level",    32'(bus.fifo_level), 32'd4);
      chk("t5 overflow", 32'(bus.overflow),   32'd0);
      chk("t5 head",     32'(bus.out_data),   32'(exp_q[1]));
      drain("t5");

      // Mid-operation reset.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(32'h3E000000 + (32'(i) << 19));
      chk("t6 pre level", 32'(bus.fifo_level), 32'd3);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("t6 out_valid", 32'(bus.out_valid),  32'd0);
      chk("t6 level",     32'(bus.fifo_level), 32'd0);
      chk("t6 warm",      32'(bus.warm),       32'd0);
      exp_q.delete();
      got_q.delete();
      clip_exp  = 0;
      clip_got  = 0;
      disc_left = 3;
      repeat (3) step();
      chk("t6 flushed", 32'(bus.fifo_level), 32'd0);
      bus.out_ready = 1'b1;
      send(32'hBF400000);
      send(32'hBF400000);
      chk("t6 warm after 2", 32'(bus.warm), 32'd0);
      send(32'hBF400000);
      chk("t6 warm after 3", 32'(bus.warm), 32'd1);
      send(32'hBF400000);
      drain("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
